// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, step encoding and IR field positions.
package seq_pkg;

    localparam logic [2:0] OPC_MV   = 3'b000;
    localparam logic [2:0] OPC_MVI  = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_SUB  = 3'b011;
    localparam logic [2:0] OPC_MVNZ = 3'b100;

    // IR layout IIIXXXYYY
    localparam int OPC_LSB = 6;
    localparam int X_LSB   = 3;
    localparam int Y_LSB   = 0;
    localparam int FIELD_W = 3;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } step_t;

    function automatic step_t step_after(input step_t s);
        case (s)
            T0:      return T1;
            T1:      return T2;
            T2:      return T3;
            default: return T0;
        endcase
    endfunction

endpackage

// File: rtl/decodificador_3para8.sv
// 3-to-8 one-hot decoder with enable; index 0 drives the MSB.
module decodificador_3para8 (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);

    assign onehot = en ? (8'b1000_0000 >> idx) : 8'b0000_0000;

endmodule

// File: rtl/sequenciador_instrucoes.sv
// Control FSM (T0..T3) for the 16-bit multicycle processor: decodes IR and drives all datapath enables.
// Optional macro SEQ_MVNZ_EN enables the conditional move (opcode 100) gated by Gnz.
module sequenciador_instrucoes
    import seq_pkg::*;
#(
    parameter int OPC_W = 3,
    parameter int NREG  = 8
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic                                 Run,
    input  logic [OPC_W+2*$clog2(NREG)-1:0]      Instrucao,
    input  logic                                 Gnz,
    output logic                                 IRin,
    output logic                                 DINout,
    output logic [NREG-1:0]                      Rin,
    output logic [NREG-1:0]                      Rout,
    output logic                                 Ain,
    output logic                                 Gin,
    output logic                                 Gout,
    output logic                                 AddSub,
    output logic                                 Done,
    output logic [1:0]                           Tstep
);

    step_t state, next;

    logic [OPC_W-1:0]   opc;
    logic [FIELD_W-1:0] x_f, y_f;

    assign opc = Instrucao[OPC_LSB +: OPC_W];
    assign x_f = Instrucao[X_LSB +: FIELD_W];
    assign y_f = Instrucao[Y_LSB +: FIELD_W];

    logic irin_c, dinout_c, ain_c, gin_c, gout_c, addsub_c, done_c;
    logic rin_en, rout_en;
    logic [FIELD_W-1:0] rin_idx, rout_idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) state <= T0;
        else       state <= next;
    end

`ifndef SEQ_MVNZ_EN
    logic unused_gnz;
    assign unused_gnz = Gnz;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default before the case, so no latch can be inferred.
        next     = state;
        irin_c   = 1'b0;
        dinout_c = 1'b0;
        ain_c    = 1'b0;
        gin_c    = 1'b0;
        gout_c   = 1'b0;
        addsub_c = 1'b0;
        done_c   = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rin_idx  = x_f;
        rout_idx = y_f;

        case (state)
            T0: begin
                if (Run) begin
                    irin_c   = 1'b1;
                    dinout_c = 1'b1;
                end
            end
            T1: begin
                case (opc)
                    OPC_W'(OPC_MV): begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        done_c  = 1'b1;
                    end
                    OPC_W'(OPC_MVI): begin
                        dinout_c = 1'b1;
                        rin_en   = 1'b1;
                        done_c   = 1'b1;
                    end
                    OPC_W'(OPC_ADD), OPC_W'(OPC_SUB): begin
                        rout_idx = x_f;
                        rout_en  = 1'b1;
                        ain_c    = 1'b1;
                    end
`ifdef SEQ_MVNZ_EN
                    OPC_W'(OPC_MVNZ): begin
                        rout_en = Gnz;
                        rin_en  = Gnz;
                        done_c  = 1'b1;
                    end
`endif
                    default: done_c = 1'b1;  // illegal opcode: finish without touching state
                endcase
            end
            T2: begin
                rout_en  = 1'b1;
                gin_c    = 1'b1;
                addsub_c = (opc == OPC_W'(OPC_SUB));
            end
            T3: begin
                gout_c = 1'b1;
                rin_en = 1'b1;
                done_c = 1'b1;
            end
        endcase

        if (state == T0) begin
            if (Run) next = T1;
        end else if (done_c) begin
            next = T0;
        end else begin
            next = step_after(state);
        end
    end

    // Reset gates every output in the same cycle, including Run's effect in T0.
    decodificador_3para8 u_dec_rin (
        .idx    (rin_idx),
        .en     (rin_en & ~Reset),
        .onehot (Rin)
    );

    decodificador_3para8 u_dec_rout (
        .idx    (rout_idx),
        .en     (rout_en & ~Reset),
        .onehot (Rout)
    );

    assign IRin   = irin_c   & ~Reset;
    assign DINout = dinout_c & ~Reset;
    assign Ain    = ain_c    & ~Reset;
    assign Gin    = gin_c    & ~Reset;
    assign Gout   = gout_c   & ~Reset;
    assign AddSub = addsub_c & ~Reset;
    assign Done   = done_c   & ~Reset;
    assign Tstep  = Reset ? 2'b00 : state;

endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// Self-checking bench: directed test-plan cases plus randomized run against an instruction-level model.
module tb_sequenciador_instrucoes;

    logic       Clock = 1'b0;
    logic       Reset, Run, Gnz;
    logic [8:0] Instrucao;
    logic       IRin, DINout, Ain, Gin, Gout, AddSub, Done;
    logic [7:0] Rin, Rout;
    logic [1:0] Tstep;

    int total = 0;
    int bad   = 0;

    sequenciador_instrucoes dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Run       (Run),
        .Instrucao (Instrucao),
        .Gnz       (Gnz),
        .IRin      (IRin),
        .DINout    (DINout),
        .Rin       (Rin),
        .Rout      (Rout),
        .Ain       (Ain),
        .Gin       (Gin),
        .Gout      (Gout),
        .AddSub    (AddSub),
        .Done      (Done),
        .Tstep     (Tstep)
    );

    always #5 Clock = ~Clock;

    // {IRin, DINout, Rin, Rout, Ain, Gin, Gout, AddSub, Done, Tstep}
    logic [24:0] dut_vec;
    assign dut_vec = {IRin, DINout, Rin, Rout, Ain, Gin, Gout, AddSub, Done, Tstep};

    function automatic logic [24:0] mk(input logic irin, input logic din, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic ain, input logic gin,
                                       input logic gout, input logic as, input logic done,
                                       input logic [1:0] ts);
        return {irin, din, rin, rout, ain, gin, gout, as, done, ts};
    endfunction

    task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: each instruction is a fixed-length list of steps.
    function automatic int instr_len(input logic [8:0] ir);
        return (ir[8:6] == 3'd2 || ir[8:6] == 3'd3) ? 3 : 1;
    endfunction

    function automatic logic [24:0] model_out(input int step, input logic [8:0] ir, input logic run,
                                              input logic gnz, input logic rst);
        logic [7:0] rx, ry, rin, rout;
        logic irin, din, ain, gin, gout, as, done;
        int op;
        op = int'(ir[8:6]);
        rx = 8'(128 >> ir[5:3]);
        ry = 8'(128 >> ir[2:0]);
        {irin, din, ain, gin, gout, as, done} = '0;
        rin = '0;
        rout = '0;
        if (rst) return '0;
        if (step == 0) begin
            irin = run;
            din  = run;
        end else begin
            done = (step == instr_len(ir));
            if (step == 1) begin
                if (op == 0) begin rout = ry; rin = rx; end
                else if (op == 1) begin din = 1; rin = rx; end
                else if (op == 2 || op == 3) begin rout = rx; ain = 1; end
`ifdef SEQ_MVNZ_EN
                else if (op == 4 && gnz) begin rout = ry; rin = rx; end
`endif
            end else if (step == 2) begin
                rout = ry; gin = 1; as = (op == 3);
            end else begin
                gout = 1; rin = rx;
            end
        end
        return mk(irin, din, rin, rout, ain, gin, gout, as, done, 2'(step));
    endfunction

    int   m_step = 0;
    int   m_next = 0;
    logic started = 1'b0;

    always @(posedge Clock) begin
        m_step  = m_next;
        started = 1'b1;
    end

    // Per-cycle compare against the model, plus a single-bus-driver check.
    always @(negedge Clock) begin
        if (started) begin
            logic [24:0] e;
            int drivers;
            e = model_out(m_step, Instrucao, Run, Gnz, Reset);
            check("model", dut_vec, e);
            drivers = int'(DINout) + int'(Gout) + $countones(Rout);
            check("one_driver", 25'(drivers <= 1), 25'd1);
            if (Reset)                                  m_next = 0;
            else if (m_step == 0)                       m_next = Run ? 1 : 0;
            else if (m_step == instr_len(Instrucao))    m_next = 0;
            else                                        m_next = m_step + 1;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic sample();
        @(negedge Clock);
    endtask

    localparam logic [8:0] I_MVI_R2  = 9'b001_010_000;
    localparam logic [8:0] I_MV_R3R2 = 9'b000_011_010;
    localparam logic [8:0] I_SUB     = 9'b011_001_010;
    localparam logic [8:0] I_ADD     = 9'b010_001_010;
    localparam logic [8:0] I_MVNZ    = 9'b100_011_010;

    logic [5:0] done_mask;

    initial begin
        Reset = 1'b1; Run = 1'b0; Instrucao = '0; Gnz = 1'b0;
        tick(); tick();
        sample();
        check("reset_outputs", dut_vec, 25'd0);
        tick();

        // mvi R2
        Reset = 1'b0; Run = 1'b1; Instrucao = I_MVI_R2;
        sample();
        check("mvi_t0", dut_vec, mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 2'b00));
        tick(); Run = 1'b0;
        sample();
        check("mvi_t1", dut_vec, mk(0, 1, 8'b0010_0000, 8'h00, 0, 0, 0, 0, 1, 2'b01));
        tick();
        sample();
        check("mvi_back_t0", dut_vec, 25'd0);

        // mv R3,R2
        Run = 1'b1; Instrucao = I_MV_R3R2;
        tick(); Run = 1'b0;
        sample();
        check("mv_t1", dut_vec, mk(0, 0, 8'b0001_0000, 8'b0010_0000, 0, 0, 0, 0, 1, 2'b01));
        tick();

        // sub R1,R2
        Run = 1'b1; Instrucao = I_SUB;
        tick(); Run = 1'b0;
        sample();
        check("sub_t1", dut_vec, mk(0, 0, 8'h00, 8'b0100_0000, 1, 0, 0, 0, 0, 2'b01));
        tick();
        sample();
        check("sub_t2", dut_vec, mk(0, 0, 8'h00, 8'b0010_0000, 0, 1, 0, 1, 0, 2'b10));
        tick();
        sample();
        check("sub_t3", dut_vec, mk(0, 0, 8'b0100_0000, 8'h00, 0, 0, 1, 0, 1, 2'b11));
        tick();

        // reset during T2 of add
        Run = 1'b1; Instrucao = I_ADD;
        tick(); Run = 1'b0;
        tick(); Reset = 1'b1;
        sample();
        check("abort_t2", dut_vec, 25'd0);
        tick(); Reset = 1'b0;
        sample();
        check("abort_after", dut_vec, 25'd0);

        // mvnz with Gnz=0 then Gnz=1
        Run = 1'b1; Instrucao = I_MVNZ; Gnz = 1'b0;
        tick(); Run = 1'b0;
        sample();
        check("mvnz_g0", dut_vec, mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 2'b01));
        tick();
        Run = 1'b1; Gnz = 1'b1;
        tick(); Run = 1'b0;
        sample();
`ifdef SEQ_MVNZ_EN
        check("mvnz_g1", dut_vec, mk(0, 0, 8'b0001_0000, 8'b0010_0000, 0, 0, 0, 0, 1, 2'b01));
`else
        check("mvnz_g1", dut_vec, mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 2'b01));
`endif
        tick();

        // Run held high: mvi then add, Done at cycles 2 and 6
        Run = 1'b1; Instrucao = I_MVI_R2; done_mask = '0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            sample();
            done_mask[cyc-1] = Done;
            tick();
            if (cyc == 2) Instrucao = I_ADD;
        end
        Run = 1'b0;
        check("b2b_done", 25'(done_mask), 25'b100010);
        tick();

        // randomized run; IR only changes while in T0
        for (int i = 0; i < 500; i++) begin
            Reset = ($urandom_range(0, 31) == 0);
            Run   = ($urandom_range(0, 3) != 0);
            Gnz   = 1'($urandom);
            if (m_step == 0) Instrucao = 9'($urandom);
            tick();
        end

        Reset = 1'b1; Run = 1'b0;
        tick();
        sample();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
